fan_line_packer: RTL and testbench
==================================

Name: fan_line_packer

Overview:
- Injection end of the FAN reduction network: accepts a serial stream of partial products tagged with output-row ids and packs them into NUM_IN-lane network lines.
- Generates each lane's ctrl field (valid / forward / row-group continuation), which the adder nodes downstream consume.
- Sits between the multiplier array output and the first adder-node stage; valid/ready on both sides, one element per cycle sustained.

Parameters:
- N_STACK, 4, data words per lane
- DW_DATA, 32, bits per data word
- DW_ROW, 4, row-id width
- DW_CTRL, 4, ctrl width (fixed at 4)
- DW_LINE, N_STACK*DW_DATA+DW_ROW+DW_CTRL, lane width
- NUM_IN, 6, lanes per packet
- DW_CNT, 16, packet-counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  element valid
- in_ready  out  1  element accepted when in_valid&&in_ready
- in_data  in  N_STACK*DW_DATA  element payload
- in_row  in  DW_ROW  element row id
- in_last  in  1  close the packet after this element
- out_valid  out  1  packet valid
- out_ready  in  1  network accepts packet
- out  out  NUM_IN*DW_LINE  packet; lane i at [i*DW_LINE +: DW_LINE], lane = {ctrl, row, data}
- pkt_count  out  DW_CNT  packets emitted, wraps modulo 2^DW_CNT

Behaviour:
- Reset: out_valid=0, out=0, pkt_count=0, in_ready=1, fill count=0, pending=0. Mid-operation reset discards partial and held packets.
- Assembly buffer: accepted element is written to lane cnt; cnt increments.
- Packet closes on the acceptance that makes cnt==NUM_IN, or on any accepted element with in_last=1.
- Output slot free = !out_valid || out_ready.
- On close with slot free: the packet, including the closing element, is tagged and loaded into the output register at the same edge. out_valid=1 the next cycle, so latency is 1 cycle from the closing acceptance. cnt returns to 0.
- On close with slot busy: set pending=1 and hold the assembly buffer.
- in_ready = !pending.
- While pending and the slot frees: load at that edge and clear pending. in_ready rises the following cycle.
- Output register holds stable while out_valid && !out_ready.
- pkt_count increments on each out_valid&&out_ready.
- Tagging for a closed packet of n valid lanes, with v_i = (i<n):
  - ctrl[3] = v_i
  - ctrl[0] (continues to higher lane) = v_i & v_{i+1} & row_i==row_{i+1}; forced 0 for lane NUM_IN-1
  - ctrl[1] (continues from lower lane) = v_i & v_{i-1} & row_i==row_{i-1}; forced 0 for lane 0
  - ctrl[2] (forward / singleton) = v_i & !ctrl[0] & !ctrl[1]
  - Lanes with i>=n are all zero, including data and row.
- Row groups are not merged across packets. A group split by a packet boundary is tagged independently in each packet.
- Simultaneous events:
  - Closing acceptance in the same cycle the output drains: direct load, no stall.
  - in_last on the element that fills lane NUM_IN-1: a single close.
- Row ordering is not checked. Non-adjacent equal rows get no continuation bits.

Decomposition:
- Package fan_pkg holds:
  - ctrl bit indices: CTRL_VALID=3, CTRL_FWD=2, CTRL_FROM_LO=1, CTRL_TO_HI=0
  - DW_LINE derivation
  - lane field offsets (data, row, ctrl)
- Sub-module fan_ctrl_tagger is purely combinational: inputs are the lane rows and n; output is the ctrl vector for all lanes. It is reused by any future re-injection stage.

Test Plan:
- Full packet, NUM_IN=6, rows 3,3,3,5,7,7 -> lane ctrl 1001,1011,1010,1100,1001,1010; out_valid exactly 1 cycle after the 6th acceptance; pkt_count=1.
- Rows 4,4 with in_last on the 2nd -> lanes0-1 ctrl 1001,1010; lanes2-5 entirely zero.
- Single element row 9 with in_last -> lane0 ctrl 1100, row 9, data intact; other lanes zero.
- out_ready=0, stream 12 back-to-back elements:
  - expected: pkt1 held stable, pending set after the 12th acceptance, in_ready=0
  - then raise out_ready: pkt1 then pkt2 on consecutive cycles, in_ready=1 on the cycle after pkt2 loads, pkt_count=2
- Continuous stream with out_ready=1 -> in_ready never drops; one packet every 6 cycles.
- Assert rst after 3 elements accepted -> next cycle out_valid=0 and pkt_count=0. Then feed 6 new elements -> packet contains only the new elements.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared constants for the FAN injection path: default sizing, ctrl bit indices
// and the {ctrl, row, data} lane layout.
package fan_pkg;
  localparam int DEF_N_STACK = 4;
  localparam int DEF_DW_DATA = 32;
  localparam int DEF_DW_ROW  = 4;
  localparam int DEF_DW_CTRL = 4;
  localparam int DEF_NUM_IN  = 6;
  localparam int DEF_DW_CNT  = 16;

  localparam int CTRL_VALID   = 3;
  localparam int CTRL_FWD     = 2;
  localparam int CTRL_FROM_LO = 1;
  localparam int CTRL_TO_HI   = 0;

  localparam int OFF_DATA = 0;

  function automatic int f_off_row(input int n_stack, input int dw_data);
    return n_stack * dw_data;
  endfunction

  function automatic int f_off_ctrl(input int n_stack, input int dw_data, input int dw_row);
    return f_off_row(n_stack, dw_data) + dw_row;
  endfunction

  function automatic int f_dw_line(input int n_stack, input int dw_data, input int dw_row);
    return f_off_ctrl(n_stack, dw_data, dw_row) + DEF_DW_CTRL;
  endfunction

  localparam int DEF_DW_LINE = f_dw_line(DEF_N_STACK, DEF_DW_DATA, DEF_DW_ROW);
endpackage

// File: rtl/fan_ctrl_tagger.sv
// Combinational ctrl generator: marks valid lanes and row-group continuation
// between adjacent lanes of one packet of i_n valid lanes.
module fan_ctrl_tagger
  import fan_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int DW_ROW  = DEF_DW_ROW,
  parameter int DW_CTRL = DEF_DW_CTRL,
  parameter int DW_N    = $clog2(DEF_NUM_IN + 1)
) (
  input  logic [NUM_IN*DW_ROW-1:0]  i_rows,
  input  logic [DW_N-1:0]           i_n,
  output logic [NUM_IN*DW_CTRL-1:0] o_ctrl
);
  logic [NUM_IN-1:0] w_v;
  logic [NUM_IN-1:0] w_hi;
  logic [NUM_IN-1:0] w_lo;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    assign w_v[i] = DW_N'(i) < i_n;

    if (i < NUM_IN - 1) begin : g_hi
      assign w_hi[i] = w_v[i] & w_v[i+1] &
                       (i_rows[i*DW_ROW +: DW_ROW] == i_rows[(i+1)*DW_ROW +: DW_ROW]);
    end else begin : g_hi_edge
      assign w_hi[i] = 1'b0;
    end

    if (i > 0) begin : g_lo
      assign w_lo[i] = w_v[i] & w_v[i-1] &
                       (i_rows[i*DW_ROW +: DW_ROW] == i_rows[(i-1)*DW_ROW +: DW_ROW]);
    end else begin : g_lo_edge
      assign w_lo[i] = 1'b0;
    end

    // A valid lane with no neighbour in its group is forwarded untouched.
    assign o_ctrl[i*DW_CTRL + CTRL_VALID]   = w_v[i];
    assign o_ctrl[i*DW_CTRL + CTRL_FWD]     = w_v[i] & ~w_hi[i] & ~w_lo[i];
    assign o_ctrl[i*DW_CTRL + CTRL_FROM_LO] = w_lo[i];
    assign o_ctrl[i*DW_CTRL + CTRL_TO_HI]   = w_hi[i];
  end
endmodule

// File: rtl/fan_line_packer.sv
// Packs a serial tagged element stream into NUM_IN-lane lines; 1 cycle from closing
// acceptance to out_valid. A close against a busy output stalls input until it loads.
module fan_line_packer
  import fan_pkg::*;
#(
  parameter int N_STACK = DEF_N_STACK,
  parameter int DW_DATA = DEF_DW_DATA,
  parameter int DW_ROW  = DEF_DW_ROW,
  parameter int DW_CTRL = DEF_DW_CTRL,
  parameter int DW_LINE = f_dw_line(N_STACK, DW_DATA, DW_ROW),
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int DW_CNT  = DEF_DW_CNT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_STACK*DW_DATA-1:0] in_data,
  input  logic [DW_ROW-1:0]         in_row,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_IN*DW_LINE-1:0] out,
  output logic [DW_CNT-1:0]         pkt_count
);
  localparam int DW_PAY   = N_STACK * DW_DATA;
  localparam int CW       = $clog2(NUM_IN + 1);
  localparam int OFF_ROW  = f_off_row(N_STACK, DW_DATA);
  localparam int OFF_CTRL = f_off_ctrl(N_STACK, DW_DATA, DW_ROW);

  logic [DW_PAY-1:0]         r_data [NUM_IN];
  logic [DW_ROW-1:0]         r_row  [NUM_IN];
  logic [CW-1:0]             r_cnt;
  logic                      r_pending;
  logic                      r_out_valid;
  logic [NUM_IN*DW_LINE-1:0] r_out;
  logic [DW_CNT-1:0]         r_pkt_count;

  logic                       w_acc;
  logic                       w_close;
  logic                       w_slot_free;
  logic                       w_load;
  logic [CW-1:0]              w_n;
  logic [DW_PAY-1:0]          w_data [NUM_IN];
  logic [NUM_IN*DW_ROW-1:0]   w_rows;
  logic [NUM_IN*DW_CTRL-1:0]  w_ctrl;
  logic [NUM_IN*DW_LINE-1:0]  w_pkt;

  assign in_ready    = !r_pending;
  assign out_valid   = r_out_valid;
  assign out         = r_out;
  assign pkt_count   = r_pkt_count;

  assign w_acc       = in_valid && !r_pending;
  assign w_close     = w_acc && (in_last || r_cnt == CW'(NUM_IN - 1));
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_load      = (w_close || r_pending) && w_slot_free;
  assign w_n         = r_cnt + CW'(w_acc);

  // The closing element bypasses the buffer so a direct load sees the full packet.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      w_data[i]                  = r_data[i];
      w_rows[i*DW_ROW +: DW_ROW] = r_row[i];
      if (w_acc && r_cnt == CW'(i)) begin
        w_data[i]                  = in_data;
        w_rows[i*DW_ROW +: DW_ROW] = in_row;
      end
    end
  end

  fan_ctrl_tagger #(
    .NUM_IN  (NUM_IN),
    .DW_ROW  (DW_ROW),
    .DW_CTRL (DW_CTRL),
    .DW_N    (CW)
  ) u_tagger (
    .i_rows (w_rows),
    .i_n    (w_n),
    .o_ctrl (w_ctrl)
  );

  always_comb begin
    w_pkt = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (CW'(i) < w_n) begin
        w_pkt[i*DW_LINE + OFF_DATA +: DW_PAY]  = w_data[i];
        w_pkt[i*DW_LINE + OFF_ROW  +: DW_ROW]  = w_rows[i*DW_ROW +: DW_ROW];
        w_pkt[i*DW_LINE + OFF_CTRL +: DW_CTRL] = w_ctrl[i*DW_CTRL +: DW_CTRL];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        r_data[i] <= '0;
        r_row[i]  <= '0;
      end
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_load) begin
        r_out       <= w_pkt;
        r_out_valid <= 1'b1;
        r_cnt       <= '0;
        r_pending   <= 1'b0;
      end else begin
        if (out_ready) begin
          r_out_valid <= 1'b0;
        end
        if (w_acc) begin
          r_data[r_cnt] <= in_data;
          r_row[r_cnt]  <= in_row;
          r_cnt         <= r_cnt + CW'(1);
          if (w_close) begin
            r_pending <= 1'b1;
          end
        end
      end
      if (r_out_valid && out_ready) begin
        r_pkt_count <= r_pkt_count + DW_CNT'(1);
      end
    end
  end
endmodule

// File: tb/tb_fan_line_packer.sv
// Directed bench for fan_line_packer: table of packets with hand-computed ctrl
// nibbles, plus backpressure, streaming and mid-packet reset sequences.
module tb_fan_line_packer;
  import fan_pkg::*;

  localparam int NS   = DEF_N_STACK;
  localparam int DD   = DEF_DW_DATA;
  localparam int DR   = DEF_DW_ROW;
  localparam int DC   = DEF_DW_CTRL;
  localparam int NI   = DEF_NUM_IN;
  localparam int DCNT = DEF_DW_CNT;
  localparam int DP   = NS * DD;
  localparam int DL   = DP + DR + DC;
  localparam int PW   = NI * DL;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DP-1:0]   in_data;
  logic [DR-1:0]   in_row;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   out;
  logic [DCNT-1:0] pkt_count;

  always #5 clk = ~clk;

  fan_line_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_row    (in_row),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .pkt_count (pkt_count)
  );

  int checks = 0;
  int errors = 0;
  int cnt_exp = 0;

  // rows/ctrl hold one nibble per lane, lane 0 in the most significant nibble.
  typedef struct packed {
    int          n;
    logic        last;
    logic [23:0] rows;
    logic [23:0] ctrl;
  } vec_t;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [23:0] x, input int i);
    return x[(NI-1-i)*4 +: 4];
  endfunction

  function automatic logic [DP-1:0] mk_data(input int tag, input int k);
    logic [DP-1:0] d;
    for (int w = 0; w < NS; w++) d[w*DD +: DD] = DD'(((w + 1) << 28) | (tag << 8) | k);
    return d;
  endfunction

  function automatic logic [PW-1:0] exp_pkt(input int n, input logic [23:0] rows,
                                            input logic [23:0] ctrl, input int tag);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < n; i++) p[i*DL +: DL] = {nib(ctrl, i), nib(rows, i), mk_data(tag, i)};
    return p;
  endfunction

  task automatic drive(input logic [DR-1:0] row, input logic [DP-1:0] d, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_row   = row;
    in_data  = d;
    in_last  = last;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  vec_t tv[6];
  logic [PW-1:0] p1, p2;

  initial begin
    tv[0] = '{n: 6, last: 1'b0, rows: 24'h333577, ctrl: 24'h9BAC9A};
    tv[1] = '{n: 2, last: 1'b1, rows: 24'h440000, ctrl: 24'h9A0000};
    tv[2] = '{n: 1, last: 1'b1, rows: 24'h900000, ctrl: 24'hC00000};
    tv[3] = '{n: 6, last: 1'b1, rows: 24'h121122, ctrl: 24'hCC9A9A};
    tv[4] = '{n: 6, last: 1'b0, rows: 24'h555555, ctrl: 24'h9BBBBA};
    tv[5] = '{n: 3, last: 1'b1, rows: 24'h233000, ctrl: 24'hC9A000};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_row = '0; in_last = 1'b0; out_ready = 1'b1;
    edge1(); edge1();
    chk("rst_out_valid", PW'(out_valid), '0);
    chk("rst_out", out, '0);
    chk("rst_pkt_count", PW'(pkt_count), '0);
    chk("rst_in_ready", PW'(in_ready), PW'(1));
    @(negedge clk); rst = 1'b0;

    // Table-driven packets with the output always ready.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < tv[v].n; k++) begin
        drive(nib(tv[v].rows, k), mk_data(v, k), tv[v].last && (k == tv[v].n - 1));
        edge1();
        chk($sformatf("v%0d_valid_k%0d", v, k), PW'(out_valid), PW'(k == tv[v].n - 1));
      end
      idle();
      chk($sformatf("v%0d_pkt", v), out, exp_pkt(tv[v].n, tv[v].rows, tv[v].ctrl, v));
      edge1();
      cnt_exp++;
      chk($sformatf("v%0d_pkt_count", v), PW'(pkt_count), PW'(cnt_exp));
    end

    // Backpressure: 12 elements with the output blocked.
    p1 = exp_pkt(6, 24'h111111, 24'h9BBBBA, 20);
    p2 = exp_pkt(6, 24'h012345, 24'hCCCCCC, 21);
    out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive((k < 6) ? 4'h1 : DR'(k - 6), mk_data((k < 6) ? 20 : 21, k % 6), 1'b0);
      edge1();
      if (k == 5) chk("bp_valid", PW'(out_valid), PW'(1));
      if (k >= 5) chk($sformatf("bp_hold_k%0d", k), out, p1);
      chk($sformatf("bp_in_ready_k%0d", k), PW'(in_ready), PW'(k != 11));
    end
    idle();
    edge1();
    chk("bp_hold_idle", out, p1);
    chk("bp_in_ready_idle", PW'(in_ready), '0);
    @(negedge clk); out_ready = 1'b1;
    edge1();
    chk("bp_pkt2", out, p2);
    chk("bp_pkt2_valid", PW'(out_valid), PW'(1));
    chk("bp_in_ready_back", PW'(in_ready), PW'(1));
    chk("bp_count1", PW'(pkt_count), PW'(cnt_exp + 1));
    edge1();
    cnt_exp += 2;
    chk("bp_drained", PW'(out_valid), '0);
    chk("bp_count2", PW'(pkt_count), PW'(cnt_exp));

    // Continuous streaming: no stall, a packet every 6 acceptances.
    for (int k = 0; k < 18; k++) begin
      drive(4'h7, mk_data(30 + k / 6, k % 6), 1'b0);
      edge1();
      chk($sformatf("st_in_ready_k%0d", k), PW'(in_ready), PW'(1));
      chk($sformatf("st_valid_k%0d", k), PW'(out_valid), PW'(k % 6 == 5));
    end
    idle();
    chk("st_last_pkt", out, exp_pkt(6, 24'h777777, 24'h9BBBBA, 32));
    edge1();
    cnt_exp += 3;
    chk("st_count", PW'(pkt_count), PW'(cnt_exp));

    // Reset in the middle of a partial packet.
    for (int k = 0; k < 3; k++) begin
      drive(4'h1, mk_data(40, k), 1'b0);
      edge1();
    end
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    edge1();
    chk("mrst_valid", PW'(out_valid), '0);
    chk("mrst_count", PW'(pkt_count), '0);
    chk("mrst_in_ready", PW'(in_ready), PW'(1));
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(nib(24'h8899AB, k), mk_data(41, k), 1'b0);
      edge1();
      chk($sformatf("mrst_valid_k%0d", k), PW'(out_valid), PW'(k == 5));
    end
    idle();
    chk("mrst_pkt", out, exp_pkt(6, 24'h8899AB, 24'h9A9ACC, 41));
    edge1();
    chk("mrst_count_after", PW'(pkt_count), PW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
